sync_fifo_reader: RTL
=====================

# sync_fifo_reader

Read-side drain engine for the synchronous pointer-flag FIFO (`sync_fifo_ptr`). It owns the FIFO's `rd_en`/`data_out`/`empty` port, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents the data as a valid/ready stream to downstream logic. Sustained throughput is one word per clock. There is no combinational path from `m_ready` to `fifo_rd_en`.

## Interface
- `DATA_WIDTH`, 8: word width; must match the FIFO's `DATA_WIDTH`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid the cycle after `fifo_rd_en` is sampled high.
- `fifo_rd_en`  out  1  FIFO `rd_en`.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  stream word (head of buffer).
- `level`  out  2  buffered word count, 0..3.

## Operation
- State:
  - `occ` (0..3): words held in the buffer.
  - `pend` (1 bit): a read was issued last cycle, so its data is on `fifo_data` this cycle.
- Issue rule: `fifo_rd_en = !fifo_empty && !flush && (occ + pend) < 3 && rst_n`.
  - It depends only on registered state, `fifo_empty`, `flush` and `rst_n`.
  - It is never asserted when `fifo_empty` is high.
- Capture: when `pend` is high, write `fifo_data` at the buffer tail at the clock edge.
- Pop: when `m_valid && m_ready`, advance the head.
- Push and pop may occur in the same cycle; `occ` is then unchanged.
- Buffer: 3-entry circular buffer with 2-bit head and tail pointers that wrap 2→0.
  - `m_valid = (occ != 0)`.
  - `m_data` = entry at head, driven from registers.
  - `level = occ`.
- Overflow is impossible by construction: `occ + pend ≤ 3` always holds. The bench asserts this.
- `flush`, when high for a cycle:
  - `fifo_rd_en` is forced low.
  - At the edge, `occ`, head and tail return to 0.
  - The word arriving that cycle (`pend`=1) is dropped, and `pend` clears.
  - A pop in the same cycle is ignored (the word is lost).
  - Words remaining in the FIFO are untouched.
- `m_data` holds its last value when `m_valid` is low; it is don't-care for checkers.

## Timing
- Reset values (async assert): `occ`=0, `pend`=0, pointers=0, buffer entries=0.
  - Outputs: `m_valid`=0, `m_data`=0, `level`=0, `fifo_rd_en`=0.
  - `fifo_rd_en` stays 0 for as long as `rst_n` is low.
- Reset mid-operation: all in-flight and buffered words are lost. The FIFO shares `rst_n` and resets together.
- Latency: `fifo_rd_en` high in cycle t → `fifo_data` valid in t+1 → `m_valid` high in t+2.
  - Empty-to-stream latency is therefore 2 cycles after `fifo_empty` falls.
- Steady state with `m_ready`=1 and a non-empty FIFO: `occ`=1, `pend`=1, one word per clock.
- Backpressure: after `m_ready` falls, at most 3 words accumulate and `fifo_rd_en` then stays low.
  - Recovery is immediate: the pop frees a slot, and `fifo_rd_en` re-asserts the following cycle.
- Ordering: words leave `m_data` in exact FIFO order; no duplication, no loss except on flush or reset.

## Structure
- Package `sync_fifo_pkg` holds:
  - `FIFO_RD_LATENCY`=1
  - `SKID_DEPTH`=3
  - the default `DATA_WIDTH`=8 shared with `sync_fifo_ptr`
- Sub-module `skid_buf3`: 3-entry circular register buffer with push, pop, clear and head output. It contains the pointer and `occ` logic.
- The top level holds `pend`, the issue rule and the flush gating.

## Test plan
- **Drain after fill:** FIFO (depth 8) pre-filled with 0x24, 0x81, 0x09, 0x63, 0x0D, 0x8D, 0x65, 0x12; `m_ready`=1.
  - Required: 8 consecutive `m_valid` cycles carrying that sequence in order.
  - `fifo_rd_en` deasserts once `fifo_empty` rises.
  - `level` ≤ 1 throughout.
- **Backpressure:** same fill with `m_ready`=0.
  - Exactly 3 `fifo_rd_en` pulses; `level` reaches 3; `fifo_rd_en` then stays 0.
  - Raising `m_ready` delivers all 8 words in order.
- **Concurrent streaming:** FIFO written every cycle with random data while `m_ready`=1.
  - After the 2-cycle fill, one word per cycle.
  - The scoreboard matches every written word; `occ + pend` ≤ 3 holds every cycle.
- **Flush:** `flush` pulsed while `level`=2 and `pend`=1.
  - Next cycle `level`=0 and `m_valid`=0; the 3 dropped words never appear.
  - The next FIFO word (0x5A) appears 2 cycles after flush deasserts.
- **Reset mid-stream:** `rst_n` pulled low with `level`=3.
  - Outputs are 0 asynchronously, before the next edge.
  - After release with the FIFO empty, `fifo_rd_en` stays 0.
- **Toggling ready:** `m_ready` toggled 1/0 every cycle over 20 words.
  - No loss or duplication; no `fifo_rd_en` while `fifo_empty`=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its read-side drain engine.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FIFO_RD_LATENCY    = 1;
    localparam int SKID_DEPTH         = 3;
    localparam int LEVEL_W            = 2;

    typedef logic [LEVEL_W-1:0] skid_ptr_t;

    // Circular pointer advance over SKID_DEPTH entries (2 wraps to 0).
    function automatic skid_ptr_t ptr_inc(input skid_ptr_t ptr);
        skid_ptr_t nxt;
        if (ptr == skid_ptr_t'(SKID_DEPTH - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = ptr + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the drain engine.
interface sync_fifo_reader_if #(
    parameter int DATA_WIDTH = sync_fifo_pkg::DEFAULT_DATA_WIDTH
);

    logic                               flush;
    logic                               fifo_empty;
    logic [DATA_WIDTH-1:0]              fifo_data;
    logic                               fifo_rd_en;
    logic                               m_valid;
    logic                               m_ready;
    logic [DATA_WIDTH-1:0]              m_data;
    logic [sync_fifo_pkg::LEVEL_W-1:0]  level;

    modport master (
        input  flush,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data,
        output level
    );

    modport slave (
        output flush,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  level
    );

endinterface

// File: rtl/skid_buf3.sv
// Three-entry circular register buffer; head word and valid are registered so
// the stream outputs come straight from flops.
module skid_buf3
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [LEVEL_W-1:0]    occ
);

    logic [DATA_WIDTH-1:0] mem_r [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_s [SKID_DEPTH];
    skid_ptr_t             head_r;
    skid_ptr_t             head_s;
    skid_ptr_t             tail_r;
    skid_ptr_t             tail_s;
    logic [LEVEL_W-1:0]    occ_r;
    logic [LEVEL_W-1:0]    occ_s;
    logic                  valid_r;
    logic                  valid_s;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [DATA_WIDTH-1:0] head_data_s;

    // Next-state for storage, pointers, occupancy and the registered head word.
    always_comb begin
        mem_s  = mem_r;
        head_s = head_r;
        tail_s = tail_r;
        occ_s  = occ_r;
        if (clear) begin
            head_s = 2'd0;
            tail_s = 2'd0;
            occ_s  = 2'd0;
        end else begin
            if (push) begin
                mem_s[tail_r] = din;
                tail_s        = ptr_inc(tail_r);
            end else begin
                tail_s = tail_r;
            end
            if (pop) begin
                head_s = ptr_inc(head_r);
            end else begin
                head_s = head_r;
            end
            case ({push, pop})
                2'b10:   occ_s = occ_r + 2'd1;
                2'b01:   occ_s = occ_r - 2'd1;
                default: occ_s = occ_r;
            endcase
        end
        valid_s = (occ_s != 2'd0);
        // On clear the old head word is kept so m_data holds while idle.
        if (clear) begin
            head_data_s = head_data_r;
        end else begin
            head_data_s = mem_s[head_s];
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            head_r      <= 2'd0;
            tail_r      <= 2'd0;
            occ_r       <= 2'd0;
            valid_r     <= 1'b0;
            head_data_r <= '0;
        end else begin
            mem_r       <= mem_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            occ_r       <= occ_s;
            valid_r     <= valid_s;
            head_data_r <= head_data_s;
        end
    end

    assign valid     = valid_r;
    assign head_data = head_data_r;
    assign occ       = occ_r;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read latency
// in a 3-entry skid buffer and presents a valid/ready stream.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_reader_if.master  bus
);

    logic                  pend_r;
    logic                  rd_en_s;
    logic [2:0]            inflight_s;
    logic                  buf_valid_s;
    logic [DATA_WIDTH-1:0] buf_data_s;
    logic [LEVEL_W-1:0]    buf_occ_s;
    logic                  pop_s;

    // Issue rule: only registered state, empty, flush and reset feed rd_en, so
    // m_ready never reaches the FIFO combinationally.
    always_comb begin
        inflight_s = {1'b0, buf_occ_s} + {2'b00, pend_r};
        rd_en_s    = !bus.fifo_empty && !bus.flush &&
                     (inflight_s < 3'(SKID_DEPTH)) && rst_n;
        pop_s      = buf_valid_s && bus.m_ready;
    end

    // A read issued this cycle lands on fifo_data next cycle; flush drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= rd_en_s;
        end
    end

    skid_buf3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush),
        .push      (pend_r),
        .pop       (pop_s),
        .din       (bus.fifo_data),
        .valid     (buf_valid_s),
        .head_data (buf_data_s),
        .occ       (buf_occ_s)
    );

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = buf_valid_s;
    assign bus.m_data     = buf_data_s;
    assign bus.level      = buf_occ_s;

endmodule
